// File: rtl/core_ctrl_if.sv
// core_ctrl_if
//   Host-facing handshake and instruction bundle of the core sequencer.
//   master : host side   (drives start/in_valid, observes the rest)
//   slave  : core_ctrl   (drives in_ready/inst/busy/done)
//   start     host -> ctrl  begin a pass (sampled in IDLE only)
//   in_valid  host -> ctrl  mem_in word valid this cycle
//   in_ready  ctrl -> host  controller accepts a mem_in word
//   inst      ctrl -> core  20-bit core instruction word
//   busy      ctrl -> host  high whenever not IDLE
//   done      ctrl -> host  one-cycle pulse on the final write-back
interface core_ctrl_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] inst;
  logic        busy;
  logic        done;

  modport master (
    output start, in_valid,
    input  in_ready, inst, busy, done
  );

  modport slave (
    input  start, in_valid,
    output in_ready, inst, busy, done
  );
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl
//   Instruction sequencer for the single-core NPU datapath. One start runs a
//   full Q*K pass: stream Q and K words into their SRAMs, load K as kernel,
//   execute, drain the ofifo into psum memory, accumulate in the SFP, then
//   divide each psum row and write it back. done pulses on the last
//   write-back, when psum memory holds the normalized results.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears all state immediately
//   bus    core_ctrl_if.slave (start, in_valid, in_ready, inst, busy, done)
// Parameters
//   col        MAC columns (number of K words loaded as kernel)
//   rows       Q vectors per pass (1..16)
//   drain_cyc  idle cycles between last execute and the first ofifo read
module core_ctrl #(
  parameter int col       = 8,
  parameter int rows      = 8,
  parameter int drain_cyc = 16
) (
  input  logic         clk,
  input  logic         reset,
  core_ctrl_if.slave   bus
);

  // inst bit positions
  localparam int B_WR2PMEM = 19;
  localparam int B_DIV     = 18;
  localparam int B_ACC     = 17;
  localparam int B_OFIFO   = 16;
  localparam int B_EXEC    = 7;
  localparam int B_KLOAD   = 6;
  localparam int B_Q_RD    = 5;
  localparam int B_Q_WR    = 4;
  localparam int B_K_RD    = 3;
  localparam int B_K_WR    = 2;
  localparam int B_P_RD    = 1;
  localparam int B_P_WR    = 0;

  // The accumulate phase counts to rows inclusive, so the counter must hold
  // the largest of rows, col and drain_cyc.
  localparam int CMAX0 = (rows > col) ? rows : col;
  localparam int CMAX  = (CMAX0 > drain_cyc) ? CMAX0 : drain_cyc;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ROWS_N     = CW'(rows);
  localparam logic [CW-1:0] ROWS_LAST  = CW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(col - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cyc - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [3:0] {
    IDLE, LOAD_Q, LOAD_K, KLOAD, KGAP, EXEC, DRAIN, OFRD, ACC,
    DV_RD, DV_DIV, DV_WB
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;

  logic [19:0]    inst_next;
  logic           in_ready_next;
  logic           done_next;
  logic [3:0]     addr;

  assign addr = cnt_reg[3:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    inst_next     = '0;
    in_ready_next = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD_Q;
          cnt_next   = '0;
        end
      end

      // A beat is a cycle with in_valid; without it the address holds.
      LOAD_Q: begin
        in_ready_next     = 1'b1;
        inst_next[B_Q_WR] = bus.in_valid;
        inst_next[15:12]  = addr;
        if (bus.in_valid) begin
          if (cnt_reg == ROWS_LAST) begin
            state_next = LOAD_K;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      LOAD_K: begin
        in_ready_next     = 1'b1;
        inst_next[B_K_WR] = bus.in_valid;
        inst_next[15:12]  = addr;
        if (bus.in_valid) begin
          if (cnt_reg == COL_LAST) begin
            state_next = KLOAD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      KLOAD: begin
        inst_next[B_K_RD]  = 1'b1;
        inst_next[B_KLOAD] = 1'b1;
        inst_next[15:12]   = addr;
        if (cnt_reg == COL_LAST) begin
          state_next = KGAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // The final kmem read lands one cycle after its address (SRAM latency),
      // so kload stays up one extra cycle with no read issued.
      KGAP: begin
        inst_next[B_KLOAD] = 1'b1;
        state_next         = EXEC;
        cnt_next           = '0;
      end

      EXEC: begin
        inst_next[B_Q_RD] = 1'b1;
        inst_next[B_EXEC] = 1'b1;
        inst_next[15:12]  = addr;
        if (cnt_reg == ROWS_LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = OFRD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // ofifo head is combinational, so pop and psum write share a cycle.
      OFRD: begin
        inst_next[B_OFIFO] = 1'b1;
        inst_next[B_P_WR]  = 1'b1;
        inst_next[11:8]    = addr;
        if (cnt_reg == ROWS_LAST) begin
          state_next = ACC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // Read of row c overlaps accumulate of row c-1; one tail cycle
      // accumulates the last row with no read.
      ACC: begin
        if (cnt_reg < ROWS_N) begin
          inst_next[B_P_RD] = 1'b1;
          inst_next[11:8]   = addr;
        end
        if (cnt_reg != '0) begin
          inst_next[B_ACC] = 1'b1;
        end
        if (cnt_reg == ROWS_N) begin
          state_next = DV_RD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      // Divide is serialized per row: psum memory is single-port, so read,
      // divide and write-back each take their own cycle.
      DV_RD: begin
        inst_next[B_P_RD] = 1'b1;
        inst_next[11:8]   = addr;
        state_next        = DV_DIV;
      end

      DV_DIV: begin
        inst_next[B_DIV] = 1'b1;
        inst_next[11:8]  = addr;
        state_next       = DV_WB;
      end

      DV_WB: begin
        inst_next[B_WR2PMEM] = 1'b1;
        inst_next[B_P_WR]    = 1'b1;
        inst_next[11:8]      = addr;
        if (cnt_reg == ROWS_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          state_next = DV_RD;
          cnt_next   = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.inst     = inst_next;
  assign bus.in_ready = in_ready_next;
  assign bus.done     = done_next;
  assign bus.busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_core_ctrl.sv
module tb_core_ctrl;
  localparam int ROWS  = 8;
  localparam int COL   = 8;
  localparam int DRAIN = 16;

  localparam int B_WR2PMEM = 19;
  localparam int B_DIV     = 18;
  localparam int B_ACC     = 17;
  localparam int B_OFIFO   = 16;
  localparam int B_EXEC    = 7;
  localparam int B_KLOAD   = 6;
  localparam int B_Q_RD    = 5;
  localparam int B_Q_WR    = 4;
  localparam int B_K_RD    = 3;
  localparam int B_K_WR    = 2;
  localparam int B_P_RD    = 1;
  localparam int B_P_WR    = 0;

  logic clk;
  logic reset;

  core_ctrl_if bus();

  core_ctrl #(.col(COL), .rows(ROWS), .drain_cyc(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard: per-cycle expected {busy, in_ready, done, inst} and the
  // in_valid to drive in that cycle.
  logic [22:0] exp_q[$];
  bit          stim_q[$];
  int          qwr_count[16];
  bit          mon_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observed();
    return 32'({bus.busy, bus.in_ready, bus.done, bus.inst});
  endfunction

  function automatic logic [19:0] bit_at(input int b);
    return 20'(1) << b;
  endfunction

  task automatic push(input bit iv, input bit rdy, input bit dn, input logic [19:0] ins);
    stim_q.push_back(iv);
    exp_q.push_back({1'b1, rdy, dn, ins});
  endtask

  // Expected pass as a flat list of cycles; stall_a/stall_b insert one idle
  // cycle (in_valid low) before the Q beat with that index.
  task automatic build_pass(input int stall_a, input int stall_b);
    logic [19:0] w;
    for (int a = 0; a < ROWS; a++) begin
      if (a == stall_a || a == stall_b)
        push(1'b0, 1'b1, 1'b0, 20'(a) << 12);
      push(1'b1, 1'b1, 1'b0, bit_at(B_Q_WR) | (20'(a) << 12));
    end
    for (int a = 0; a < COL; a++)
      push(1'b1, 1'b1, 1'b0, bit_at(B_K_WR) | (20'(a) << 12));
    for (int a = 0; a < COL; a++)
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0,
           bit_at(B_K_RD) | bit_at(B_KLOAD) | (20'(a) << 12));
    push(1'($urandom_range(0, 1)), 1'b0, 1'b0, bit_at(B_KLOAD));
    for (int a = 0; a < ROWS; a++)
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0,
           bit_at(B_Q_RD) | bit_at(B_EXEC) | (20'(a) << 12));
    for (int a = 0; a < DRAIN; a++)
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0, 20'h0);
    for (int a = 0; a < ROWS; a++)
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0,
           bit_at(B_OFIFO) | bit_at(B_P_WR) | (20'(a) << 8));
    for (int c = 0; c <= ROWS; c++) begin
      w = 20'h0;
      if (c < ROWS) w = w | bit_at(B_P_RD) | (20'(c) << 8);
      if (c >= 1)   w = w | bit_at(B_ACC);
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0, w);
    end
    for (int r = 0; r < ROWS; r++) begin
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0, bit_at(B_P_RD) | (20'(r) << 8));
      push(1'($urandom_range(0, 1)), 1'b0, 1'b0, bit_at(B_DIV) | (20'(r) << 8));
      push(1'($urandom_range(0, 1)), 1'b0, (r == ROWS - 1),
           bit_at(B_WR2PMEM) | bit_at(B_P_WR) | (20'(r) << 8));
    end
  endtask

  // Safety invariants, every cycle while out of reset.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      check_eq("invariant",
               32'({bus.inst[B_Q_WR] & bus.inst[B_Q_RD],
                    bus.inst[B_K_WR] & bus.inst[B_K_RD],
                    bus.inst[B_P_WR] & bus.inst[B_P_RD],
                    bus.inst[B_EXEC] & bus.inst[B_KLOAD]}),
               32'h0);
    end
  end

  task automatic run_pass(input string name, input int stall_a, input int stall_b,
                          input int start_cyc, input int abort_cyc, input int exp_done);
    int done_cyc;
    int done_cnt;
    logic [22:0] e;
    bit aborted;
    done_cyc = 0;
    done_cnt = 0;
    aborted  = 0;
    for (int i = 0; i < 16; i++) qwr_count[i] = 0;
    exp_q.delete();
    stim_q.delete();
    build_pass(stall_a, stall_b);

    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; exp_q.size() > 0; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      bus.in_valid = stim_q.pop_front();
      bus.start    = (c == start_cyc);
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s_c%0d", name, c), observed(), 32'(e));
      if (bus.inst[B_Q_WR]) qwr_count[bus.inst[15:12]]++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == abort_cyc) begin
        #1 reset = 1'b0;
        #1 check_eq($sformatf("%s_abort_outputs", name), observed(), 32'h0);
        aborted = 1;
        exp_q.delete();
        stim_q.delete();
        break;
      end
    end
    bus.start = 1'b0;

    check_eq($sformatf("%s_done_cycle", name), 32'(done_cyc), 32'(exp_done));
    check_eq($sformatf("%s_done_count", name), 32'(done_cnt), aborted ? 32'd0 : 32'd1);

    if (aborted) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.start    = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq($sformatf("%s_in_reset%0d", name, k), observed(), 32'h0);
      end
      bus.start = 1'b0;
      #2 reset = 1'b1;
    end else begin
      for (int a = 0; a < ROWS; a++)
        check_eq($sformatf("%s_qwr_addr%0d", name, a), 32'(qwr_count[a]), 32'd1);
      // Back in IDLE: in_valid must be ignored.
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_eq($sformatf("%s_idle_after", name), observed(), 32'h0);
      bus.in_valid = 1'b0;
    end
    $display("pass %s: done_cycle=%0d done_count=%0d aborted=%0d", name, done_cyc, done_cnt, aborted);
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;

    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      bus.start    = k[0];
      bus.in_valid = ~k[0];
      @(negedge clk);
      check_eq($sformatf("reset_hold%0d", k), observed(), 32'h0);
    end
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    mon_en       = 1'b1;
    @(negedge clk);
    check_eq("reset_release_idle", observed(), 32'h0);

    run_pass("full",        -1, -1,  0,  0, 90);
    run_pass("stall",        2,  5,  0,  0, 92);
    run_pass("start_in_exec", -1, -1, 28,  0, 90);
    run_pass("abort_dvdiv",  -1, -1,  0, 80,  0);
    run_pass("restart",      -1, -1,  0,  0, 90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
